// File: rtl/roi_downsampler_if.sv
// Capture-control, frame-buffer fetch and output-write bus of roi_downsampler.
interface roi_downsampler_if #(
  parameter int DATA_W = 10,
  parameter int CH     = 3,
  parameter int ADDR_W = 14
);
  logic                 i_start;
  logic                 i_abort;
  logic [CH*DATA_W-1:0] i_pix;
  logic                 o_read_request;
  logic                 o_wr_en;
  logic [ADDR_W-1:0]    o_wr_addr;
  logic [CH*DATA_W-1:0] o_wr_data;
  logic                 o_busy;
  logic                 o_finish;

  modport master (
    output i_start, i_abort, i_pix,
    input  o_read_request, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_finish
  );

  modport slave (
    input  i_start, i_abort, i_pix,
    output o_read_request, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_finish
  );
endinterface

// File: rtl/roi_downsampler.sv
// Captures one frame's region of interest and writes it decimated by 2^DEC_LOG2 in
// both axes, either point-sampled or horizontally box-averaged.
module roi_downsampler #(
  parameter int DATA_W   = 10,
  parameter int CH       = 3,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int X_START  = 272,
  parameter int Y_START  = 83,
  parameter int ROI_W    = 256,
  parameter int ROI_H    = 256,
  parameter int DEC_LOG2 = 1,
  parameter int MODE     = 0,
  parameter int ADDR_W   = 14
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  roi_downsampler_if.slave bus
);
  localparam int DEC   = 1 << DEC_LOG2;
  localparam int PIX_W = CH * DATA_W;
  localparam int SUM_W = DATA_W + DEC_LOG2;
  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] X_ORG  = HW'(X_START);
  localparam logic [VW-1:0] Y_ORG  = VW'(Y_START);
  localparam logic [HW-1:0] H_GRP  = HW'(DEC - 1);
  localparam logic [VW-1:0] V_GRP  = VW'(DEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [HW-1:0]       h, h_nxt;
  logic [VW-1:0]       v, v_nxt;
  logic [HW-1:0]       g;
  logic                in_win, grp_first, grp_last, fire;
  logic [ADDR_W-1:0]   addr;
  logic [SUM_W-1:0]    acc [CH];
  logic [SUM_W-1:0]    acc_nxt [CH];
  logic [PIX_W-1:0]    wr_data_nxt;
  logic                rd_req, wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [PIX_W-1:0]    wr_data;

  function automatic logic row_in_roi(input int vv);
    return (vv >= Y_START) && (vv < Y_START + ROI_H);
  endfunction

  // Fetch runs two columns ahead of use to cover the frame-buffer read latency.
  function automatic logic fetch_col(input int hh);
    return (hh >= X_START - 2) && (hh < X_START + ROI_W - 2);
  endfunction

  function automatic logic pix_col(input int hh);
    return (hh >= X_START) && (hh < X_START + ROI_W);
  endfunction

  function automatic logic [DATA_W-1:0] avg_trunc(input logic [SUM_W-1:0] s);
    return DATA_W'(s >> DEC_LOG2);
  endfunction

  always_comb begin
    state_nxt = state;
    h_nxt     = h;
    v_nxt     = v;
    unique case (state)
      IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (bus.i_start) state_nxt = RUN;
      end
      RUN: begin
        if (bus.i_abort) begin
          state_nxt = IDLE;
          h_nxt     = '0;
          v_nxt     = '0;
        end else if (h == H_LAST) begin
          h_nxt = '0;
          if (v == V_LAST) begin
            state_nxt = DONE;
            v_nxt     = '0;
          end else begin
            v_nxt = v + 1'b1;
          end
        end else begin
          h_nxt = h + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        h_nxt     = '0;
        v_nxt     = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    g         = (h - X_ORG) & H_GRP;
    grp_first = (g == '0);
    grp_last  = (g == H_GRP);
    in_win    = (state == RUN) && pix_col(int'(h)) && row_in_roi(int'(v))
                && (((v - Y_ORG) & V_GRP) == '0);
    fire      = in_win && grp_last && !bus.i_abort;
    acc_nxt     = acc;
    wr_data_nxt = '0;
    for (int k = 0; k < CH; k++) begin
      if (MODE == 1) begin
        acc_nxt[k] = grp_first ? SUM_W'(bus.i_pix[k*DATA_W +: DATA_W])
                               : acc[k] + SUM_W'(bus.i_pix[k*DATA_W +: DATA_W]);
        wr_data_nxt[k*DATA_W +: DATA_W] = avg_trunc(acc_nxt[k]);
      end else begin
        acc_nxt[k] = grp_first ? SUM_W'(bus.i_pix[k*DATA_W +: DATA_W]) : acc[k];
        wr_data_nxt[k*DATA_W +: DATA_W] = acc_nxt[k][DATA_W-1:0];
      end
    end
  end

  // Stage boundary: counters, fetch strobe, group accumulator and write port.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      h       <= '0;
      v       <= '0;
      addr    <= '0;
      rd_req  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int k = 0; k < CH; k++) acc[k] <= '0;
    end else begin
      state  <= state_nxt;
      h      <= h_nxt;
      v      <= v_nxt;
      rd_req <= (state_nxt == RUN) && fetch_col(int'(h_nxt)) && row_in_roi(int'(v_nxt));
      wr_en  <= fire;
      if (in_win) acc <= acc_nxt;
      if (state == IDLE && bus.i_start) begin
        addr <= '0;
      end else if (fire) begin
        wr_addr <= addr;
        wr_data <= wr_data_nxt;
        addr    <= addr + 1'b1;
      end
    end
  end

  assign bus.o_read_request = rd_req;
  assign bus.o_wr_en        = wr_en;
  assign bus.o_wr_addr      = wr_addr;
  assign bus.o_wr_data      = wr_data;
  assign bus.o_busy         = (state == RUN);
  assign bus.o_finish       = (state == DONE);
endmodule

// File: tb/tb_roi_downsampler.sv
// Two downsampler instances (point-sample /4 and box-average /2) fed from one frame
// buffer model; expected writes are computed per frame from the ROI image.
module tb_roi_downsampler;
  localparam int DATA_W = 10;
  localparam int CH     = 3;
  localparam int PW     = CH * DATA_W;
  localparam int HT     = 40;
  localparam int VT     = 14;
  localparam int XS     = 6;
  localparam int YS     = 3;
  localparam int RW     = 16;
  localparam int RH     = 8;
  localparam int AW     = 8;
  localparam int FRAME  = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  roi_downsampler_if #(.DATA_W(DATA_W), .CH(CH), .ADDR_W(AW)) bus_a ();
  roi_downsampler_if #(.DATA_W(DATA_W), .CH(CH), .ADDR_W(AW)) bus_b ();

  roi_downsampler #(
    .DATA_W(DATA_W), .CH(CH), .H_TOTAL(HT), .V_TOTAL(VT), .X_START(XS), .Y_START(YS),
    .ROI_W(RW), .ROI_H(RH), .DEC_LOG2(2), .MODE(0), .ADDR_W(AW)
  ) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));

  roi_downsampler #(
    .DATA_W(DATA_W), .CH(CH), .H_TOTAL(HT), .V_TOTAL(VT), .X_START(XS), .Y_START(YS),
    .ROI_W(RW), .ROI_H(RH), .DEC_LOG2(1), .MODE(1), .ADDR_W(AW)
  ) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  typedef struct {
    int            addr;
    logic [PW-1:0] data;
  } wr_t;

  wr_t           qa[$];
  wr_t           qb[$];
  logic [PW-1:0] img [RH][RW];
  int            checks = 0;
  int            errors = 0;
  int            pattern = 0;
  bit            m_run = 0;
  bit            m_done = 0;
  int            m_k = 0;
  int            req_idx = 0;
  bit            cur_rr = 0;
  logic [PW-1:0] d1 = '0, d2 = '0;
  bit            d1v = 0, d2v = 0;
  logic [63:0]   last_addr_a = '0, last_addr_b = '0;
  logic [63:0]   last_data_a = '0, last_data_b = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] grey(input int x);
    logic [DATA_W-1:0] c;
    c = DATA_W'(x);
    return {c, c, c};
  endfunction

  // Fetch window of the frame position k cycles after the start edge.
  function automatic bit exp_rr(input int k);
    int hh, vv;
    hh = k % HT;
    vv = k / HT;
    return (hh >= XS - 2) && (hh < XS + RW - 2) && (vv >= YS) && (vv < YS + RH);
  endfunction

  task automatic load_frame();
    logic [PW-1:0] p0, p1, avg;
    int a, b;
    for (int r = 0; r < RH; r++)
      for (int c = 0; c < RW; c++)
        img[r][c] = (pattern == 1) ? ((c % 2 == 0) ? grey(100) : grey(201)) : PW'($urandom);
    qa.delete();
    qb.delete();
    for (int r = 0; r < RH; r += 4)
      for (int j = 0; j < RW / 4; j++)
        qa.push_back('{(r / 4) * (RW / 4) + j, img[r][4 * j]});
    for (int r = 0; r < RH; r += 2)
      for (int j = 0; j < RW / 2; j++) begin
        p0 = img[r][2 * j];
        p1 = img[r][2 * j + 1];
        avg = '0;
        for (int ch = 0; ch < CH; ch++) begin
          a = int'(p0[ch * DATA_W +: DATA_W]);
          b = int'(p1[ch * DATA_W +: DATA_W]);
          avg[ch * DATA_W +: DATA_W] = DATA_W'((a + b) / 2);
        end
        qb.push_back('{(r / 2) * (RW / 2) + j, avg});
      end
  endtask

  task automatic check_wr(input bit side_b, input logic en, input logic [AW-1:0] addr,
                          input logic [PW-1:0] data);
    wr_t e;
    int  n;
    n = side_b ? qb.size() : qa.size();
    if (en === 1'b1 && n > 0) begin
      e = side_b ? qb.pop_front() : qa.pop_front();
      chk(side_b ? "wr_addr_b" : "wr_addr_a", 64'(addr), 64'(e.addr));
      chk(side_b ? "wr_data_b" : "wr_data_a", 64'(data), 64'(e.data));
      if (side_b) begin last_addr_b = 64'(e.addr); last_data_b = 64'(e.data); end
      else begin last_addr_a = 64'(e.addr); last_data_a = 64'(e.data); end
    end else if (en === 1'b1) begin
      chk(side_b ? "spurious_wr_b" : "spurious_wr_a", 64'(en), 64'(0));
    end else begin
      chk(side_b ? "wr_en_b" : "wr_en_a", 64'(en), 64'(0));
      chk(side_b ? "hold_addr_b" : "hold_addr_a", 64'(addr), side_b ? last_addr_b : last_addr_a);
      chk(side_b ? "hold_data_b" : "hold_data_a", 64'(data), side_b ? last_data_b : last_data_a);
    end
  endtask

  // Monitor, reference model and frame-buffer source, all on the falling edge.
  initial forever begin
    @(negedge clk);
    cur_rr = m_run && exp_rr(m_k);
    chk("busy_a", 64'(bus_a.o_busy), 64'(m_run));
    chk("busy_b", 64'(bus_b.o_busy), 64'(m_run));
    chk("finish_a", 64'(bus_a.o_finish), 64'(m_done));
    chk("finish_b", 64'(bus_b.o_finish), 64'(m_done));
    chk("read_req_a", 64'(bus_a.o_read_request), 64'(cur_rr));
    chk("read_req_b", 64'(bus_b.o_read_request), 64'(cur_rr));
    if (m_done) begin
      chk("missing_wr_a", 64'(qa.size()), 64'(0));
      chk("missing_wr_b", 64'(qb.size()), 64'(0));
    end
    check_wr(1'b0, bus_a.o_wr_en, bus_a.o_wr_addr, bus_a.o_wr_data);
    check_wr(1'b1, bus_b.o_wr_en, bus_b.o_wr_addr, bus_b.o_wr_data);

    if (!rst_n) begin
      m_run = 0; m_done = 0; m_k = 0;
      qa.delete(); qb.delete();
      last_addr_a = '0; last_addr_b = '0; last_data_a = '0; last_data_b = '0;
      cur_rr = 0; d1v = 0; d2v = 0;
    end else if (m_run) begin
      if (bus_a.i_abort) begin
        m_run = 0;
        qa.delete(); qb.delete();
      end else if (m_k == FRAME - 1) begin
        m_run = 0;
        m_done = 1;
      end else begin
        m_k++;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (bus_a.i_start) begin
      m_run = 1; m_k = 0; req_idx = 0;
      load_frame();
    end

    bus_a.i_pix = d2v ? d2 : PW'($urandom);
    bus_b.i_pix = bus_a.i_pix;
    d2 = d1; d2v = d1v;
    d1v = cur_rr && (req_idx < RW * RH);
    if (d1v) begin
      d1 = img[req_idx / RW][req_idx % RW];
      req_idx++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic a);
    bus_a.i_start = s; bus_b.i_start = s;
    bus_a.i_abort = a; bus_b.i_abort = a;
  endtask

  task automatic pulse_start();
    set_in(1'b1, 1'b0);
    cyc(1);
    set_in(1'b0, 1'b0);
  endtask

  task automatic wait_finish(input int budget);
    int n = 0;
    while (bus_a.o_finish !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
    chk("finish_seen", 64'(bus_a.o_finish), 64'(1));
  endtask

  task automatic wait_wr_b(input int target, input int budget);
    int n = 0;
    while (!(bus_b.o_wr_en === 1'b1 && int'(bus_b.o_wr_addr) == target) && n < budget) begin
      cyc(1);
      n++;
    end
    chk("abort_point_seen", 64'(bus_b.o_wr_addr), 64'(target));
  endtask

  initial begin
    set_in(1'b0, 1'b0);
    bus_a.i_pix = '0;
    bus_b.i_pix = '0;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Random frame.
    pulse_start();
    wait_finish(FRAME + 10);
    cyc(3);

    // Alternating 100/201 frame; start+abort together still starts; starts in RUN ignored.
    pattern = 1;
    set_in(1'b1, 1'b1);
    cyc(1);
    set_in(1'b0, 1'b0);
    cyc(200);
    pulse_start();
    cyc(50);
    pulse_start();
    wait_finish(FRAME + 10);
    set_in(1'b0, 1'b1);
    cyc(1);
    set_in(1'b0, 1'b0);
    pattern = 0;
    cyc(2);

    // Abort while idle is ignored; abort mid-frame stops writing.
    set_in(1'b0, 1'b1);
    cyc(2);
    set_in(1'b0, 1'b0);
    pulse_start();
    wait_wr_b(20, FRAME);
    set_in(1'b0, 1'b1);
    cyc(1);
    set_in(1'b0, 1'b0);
    cyc(HT * 3);
    pulse_start();
    wait_finish(FRAME + 10);
    cyc(3);

    // One-clock reset mid-frame, then a clean frame.
    pulse_start();
    cyc(FRAME / 2);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(HT * 2);
    pulse_start();
    wait_finish(FRAME + 10);
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
